// File: rtl/cpu_mmu_fill_ctl_if.sv
// Bus bundle for the MMU miss/fill sequencer: CPU access handshake, hit
// detector results, memory read port, tag-bank write port and statistics.
// The sequencer uses the slave view; the CPU/memory side uses master.
interface cpu_mmu_fill_ctl_if;
  logic        REQ;
  logic [13:0] CPN_23_10;
  logic        HIT0_n;
  logic        HIT1_n;
  logic        MEM_REQ;
  logic        MEM_ACK;
  logic        MEM_ERR;
  logic        TAG_WE;
  logic        TAG_BANK;
  logic [13:0] TAG_DATA;
  logic        DONE;
  logic        ERR;
  logic        CLR_CNT;
  logic [15:0] HIT_CNT;
  logic [15:0] MISS_CNT;

  modport slave (
    input  REQ, CPN_23_10, HIT0_n, HIT1_n, MEM_ACK, MEM_ERR, CLR_CNT,
    output MEM_REQ, TAG_WE, TAG_BANK, TAG_DATA, DONE, ERR, HIT_CNT, MISS_CNT
  );

  modport master (
    output REQ, CPN_23_10, HIT0_n, HIT1_n, MEM_ACK, MEM_ERR, CLR_CNT,
    input  MEM_REQ, TAG_WE, TAG_BANK, TAG_DATA, DONE, ERR, HIT_CNT, MISS_CNT
  );
endinterface

// File: rtl/cpu_mmu_fill_ctl.sv
// Miss/fill sequencer for the two-bank MMU hit detector. A CPU request is
// looked up; on a miss the page is fetched from memory, its number written
// into the round-robin victim tag bank, and the lookup retried once.
// Saturating first-lookup hit/miss counters are kept for the microcode.
// Every output is a flop loaded from the decode of the state being entered.
module cpu_mmu_fill_ctl #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic              sysclk,
  input  logic              sys_rst,
  cpu_mmu_fill_ctl_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOOKUP  = 3'd1,
    ST_FILL    = 3'd2,
    ST_WRTAG   = 3'd3,
    ST_DONE    = 3'd4,
    ST_FAIL    = 3'd5,
    ST_RELEASE = 3'd6
  } state_t;

  // Last timer value of a FILL that still has no ACK; leaving FILL from
  // here keeps MEM_REQ high for exactly TIMEOUT_CYC cycles.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYC - 32'd1);

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    logic [15:0] r;
    if (v == 16'hFFFF) begin
      r = v;
    end else begin
      r = v + 16'd1;
    end
    return r;
  endfunction

  state_t      state_r, state_nx_s;
  logic [13:0] cpn_r, cpn_nx_s;
  logic        retry_r, retry_nx_s;
  logic        victim_r, victim_nx_s;
  logic [7:0]  timer_r, timer_nx_s;
  logic [15:0] hit_cnt_r, hit_cnt_nx_s;
  logic [15:0] miss_cnt_r, miss_cnt_nx_s;
  logic        mem_req_r, mem_req_nx_s;
  logic        tag_we_r, tag_we_nx_s;
  logic        done_r, done_nx_s;
  logic        err_r, err_nx_s;
  logic        hit_s;
  logic        first_lookup_s;
  logic        accept_s;

  assign hit_s          = ~bus.HIT0_n | ~bus.HIT1_n;
  assign first_lookup_s = (state_r == ST_LOOKUP) & ~retry_r;
  assign accept_s       = (state_r == ST_IDLE) & bus.REQ;

  // State register.
  always_ff @(posedge sysclk or posedge sys_rst) begin
    if (sys_rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state decode; an ACK in the timer's last cycle beats the timeout.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.REQ) state_nx_s = ST_LOOKUP;
        else         state_nx_s = ST_IDLE;
      end
      ST_LOOKUP: begin
        if (hit_s)         state_nx_s = ST_DONE;
        else if (!retry_r) state_nx_s = ST_FILL;
        else               state_nx_s = ST_FAIL;
      end
      ST_FILL: begin
        if (bus.MEM_ACK) begin
          if (bus.MEM_ERR) state_nx_s = ST_FAIL;
          else             state_nx_s = ST_WRTAG;
        end else if (timer_r == TMO_LAST) begin
          state_nx_s = ST_FAIL;
        end else begin
          state_nx_s = ST_FILL;
        end
      end
      ST_WRTAG:   state_nx_s = ST_LOOKUP;
      ST_DONE:    state_nx_s = ST_RELEASE;
      ST_FAIL:    state_nx_s = ST_RELEASE;
      ST_RELEASE: begin
        if (bus.REQ) state_nx_s = ST_RELEASE;
        else         state_nx_s = ST_IDLE;
      end
      default:    state_nx_s = ST_IDLE;
    endcase
  end

  // Output and datapath next values, decoded from the state being entered.
  always_comb begin
    mem_req_nx_s = (state_nx_s == ST_FILL);
    tag_we_nx_s  = (state_nx_s == ST_WRTAG);
    done_nx_s    = (state_nx_s == ST_DONE);
    err_nx_s     = (state_nx_s == ST_FAIL);

    if (accept_s) cpn_nx_s = bus.CPN_23_10;
    else          cpn_nx_s = cpn_r;

    if (state_r == ST_WRTAG) retry_nx_s = 1'b1;
    else if (accept_s)       retry_nx_s = 1'b0;
    else                     retry_nx_s = retry_r;

    // Victim advances only when a tag write actually completes.
    if (state_r == ST_WRTAG) victim_nx_s = ~victim_r;
    else                     victim_nx_s = victim_r;

    if ((state_r == ST_FILL) && (state_nx_s == ST_FILL)) timer_nx_s = timer_r + 8'd1;
    else                                                 timer_nx_s = 8'd0;

    // Clear has priority over a same-cycle increment.
    if (bus.CLR_CNT) begin
      hit_cnt_nx_s  = 16'd0;
      miss_cnt_nx_s = 16'd0;
    end else if (first_lookup_s) begin
      if (hit_s) begin
        hit_cnt_nx_s  = sat_inc(hit_cnt_r);
        miss_cnt_nx_s = miss_cnt_r;
      end else begin
        hit_cnt_nx_s  = hit_cnt_r;
        miss_cnt_nx_s = sat_inc(miss_cnt_r);
      end
    end else begin
      hit_cnt_nx_s  = hit_cnt_r;
      miss_cnt_nx_s = miss_cnt_r;
    end
  end

  // Registered outputs and datapath state; reset abandons any fill in flight.
  always_ff @(posedge sysclk or posedge sys_rst) begin
    if (sys_rst) begin
      mem_req_r  <= 1'b0;
      tag_we_r   <= 1'b0;
      done_r     <= 1'b0;
      err_r      <= 1'b0;
      cpn_r      <= 14'd0;
      retry_r    <= 1'b0;
      victim_r   <= 1'b0;
      timer_r    <= 8'd0;
      hit_cnt_r  <= 16'd0;
      miss_cnt_r <= 16'd0;
    end else begin
      mem_req_r  <= mem_req_nx_s;
      tag_we_r   <= tag_we_nx_s;
      done_r     <= done_nx_s;
      err_r      <= err_nx_s;
      cpn_r      <= cpn_nx_s;
      retry_r    <= retry_nx_s;
      victim_r   <= victim_nx_s;
      timer_r    <= timer_nx_s;
      hit_cnt_r  <= hit_cnt_nx_s;
      miss_cnt_r <= miss_cnt_nx_s;
    end
  end

  assign bus.MEM_REQ  = mem_req_r;
  assign bus.TAG_WE   = tag_we_r;
  assign bus.TAG_BANK = victim_r;
  assign bus.TAG_DATA = cpn_r;
  assign bus.DONE     = done_r;
  assign bus.ERR      = err_r;
  assign bus.HIT_CNT  = hit_cnt_r;
  assign bus.MISS_CNT = miss_cnt_r;

endmodule

// File: tb/tb_cpu_mmu_fill_ctl.sv
// Self-checking bench for cpu_mmu_fill_ctl. A small reference model predicts
// each access outcome into a scoreboard queue; the driver runs the access,
// acting as CPU, hit detector and memory, and each test pops and compares.
module tb_cpu_mmu_fill_ctl;

  localparam int TMO = 4;

  typedef struct {
    logic        done;
    int          lat;
    int          memreq;
    int          tagwe;
    logic        bank;
    logic [13:0] data;
    int          extra;
  } acc_t;

  logic sysclk;
  logic sys_rst;
  int   n_vec = 0;
  int   n_bad = 0;

  logic        m_victim;
  logic [15:0] m_hit;
  logic [15:0] m_miss;
  acc_t        exp_q[$];

  cpu_mmu_fill_ctl_if bus ();

  cpu_mmu_fill_ctl #(.TIMEOUT_CYC(TMO)) dut (
    .sysclk (sysclk),
    .sys_rst(sys_rst),
    .bus    (bus)
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  initial begin
    #5000000;
    $display("FAIL watchdog: got no finish by time limit, want finish");
    $fatal(1, "watchdog expired");
  end

  // Reference model: predict outcome of one access and push it.
  task automatic predict(input logic [13:0] cpn, input logic [1:0] first_n,
                         input logic [1:0] retry_n, input int ack_at,
                         input logic err_in, input logic clr);
    acc_t e;
    e.done = 1'b0; e.lat = 0; e.memreq = 0; e.tagwe = 0;
    e.bank = 1'b0; e.data = 14'd0; e.extra = 0;
    if (first_n != 2'b11) begin
      e.done = 1'b1;
      e.lat  = 2;
      if (m_hit != 16'hFFFF) m_hit = m_hit + 16'd1;
    end else begin
      if (m_miss != 16'hFFFF) m_miss = m_miss + 16'd1;
      if (ack_at == 0 || ack_at > TMO) begin
        e.memreq = TMO;
        e.lat    = TMO + 2;
      end else if (err_in) begin
        e.memreq = ack_at;
        e.lat    = ack_at + 2;
      end else begin
        e.memreq = ack_at;
        e.tagwe  = 1;
        e.bank   = m_victim;
        e.data   = cpn;
        m_victim = ~m_victim;
        e.lat    = ack_at + 4;
        e.done   = (retry_n != 2'b11);
      end
    end
    if (clr) begin
      m_hit  = 16'd0;
      m_miss = 16'd0;
    end
    exp_q.push_back(e);
  endtask

  // Driver: run one access from IDLE and record what the DUT did.
  // Cycle numbering: REQ sampled at edge 0, state after edge k is cycle k.
  task automatic access(input logic [13:0] cpn, input logic [1:0] first_n,
                        input logic [1:0] retry_n, input int ack_at,
                        input logic err_in, input logic clr, input int hold,
                        output acc_t o);
    int fills;
    o.done = 1'b0; o.lat = 0; o.memreq = 0; o.tagwe = 0;
    o.bank = 1'b0; o.data = 14'd0; o.extra = 0;
    fills = 0;
    bus.CPN_23_10 = cpn;
    {bus.HIT1_n, bus.HIT0_n} = first_n;
    bus.REQ = 1'b1;
    for (int cyc = 1; cyc <= 100; cyc++) begin
      @(posedge sysclk); #1;
      bus.MEM_ACK = 1'b0;
      bus.MEM_ERR = 1'b0;
      bus.CLR_CNT = (clr && cyc == 1);
      if (bus.MEM_REQ) begin
        o.memreq++;
        fills++;
        if (fills == ack_at) begin
          bus.MEM_ACK = 1'b1;
          bus.MEM_ERR = err_in;
        end
      end
      if (bus.TAG_WE) begin
        o.tagwe++;
        o.bank = bus.TAG_BANK;
        o.data = bus.TAG_DATA;
        {bus.HIT1_n, bus.HIT0_n} = retry_n;
      end
      if (bus.DONE || bus.ERR) begin
        o.done = bus.DONE;
        o.lat  = cyc;
        if (bus.DONE && bus.ERR) o.extra++;
        break;
      end
    end
    bus.MEM_ACK = 1'b0;
    bus.MEM_ERR = 1'b0;
    bus.CLR_CNT = 1'b0;
    repeat (hold) begin
      @(posedge sysclk); #1;
      if (bus.DONE || bus.ERR || bus.MEM_REQ || bus.TAG_WE) o.extra++;
    end
    bus.REQ = 1'b0;
    repeat (2) begin
      @(posedge sysclk); #1;
      if (bus.DONE || bus.ERR || bus.MEM_REQ || bus.TAG_WE) o.extra++;
    end
  endtask

  task automatic test_reset;
    sys_rst = 1'b1;
    bus.REQ = 1'b0; bus.CPN_23_10 = 14'd0; bus.HIT0_n = 1'b1; bus.HIT1_n = 1'b1;
    bus.MEM_ACK = 1'b0; bus.MEM_ERR = 1'b0; bus.CLR_CNT = 1'b0;
    m_victim = 1'b0; m_hit = 16'd0; m_miss = 16'd0;
    repeat (3) @(posedge sysclk);
    #1;
    n_vec++;
    if ({bus.MEM_REQ, bus.TAG_WE, bus.TAG_BANK, bus.DONE, bus.ERR} !== 5'b00000) begin
      n_bad++;
      $display("FAIL reset_ctrl: got %b, want 00000", {bus.MEM_REQ, bus.TAG_WE, bus.TAG_BANK, bus.DONE, bus.ERR});
    end
    n_vec++;
    if ({bus.TAG_DATA, bus.HIT_CNT, bus.MISS_CNT} !== 46'd0) begin
      n_bad++;
      $display("FAIL reset_data: got %h/%h/%h, want 0/0/0", bus.TAG_DATA, bus.HIT_CNT, bus.MISS_CNT);
    end
    @(negedge sysclk);
    sys_rst = 1'b0;
    @(posedge sysclk); #1;
  endtask

  task automatic test_hit;
    acc_t o, e;
    predict(14'h0123, 2'b01, 2'b11, 0, 1'b0, 1'b0);
    access(14'h0123, 2'b01, 2'b11, 0, 1'b0, 1'b0, 0, o);
    e = exp_q.pop_front();
    n_vec++;
    if (o.lat !== e.lat || o.done !== e.done) begin
      n_bad++; $display("FAIL hit_done: got lat %0d done %b, want lat %0d done %b", o.lat, o.done, e.lat, e.done);
    end
    n_vec++;
    if (o.memreq !== 0 || o.tagwe !== 0 || o.extra !== 0) begin
      n_bad++; $display("FAIL hit_side: got memreq %0d tagwe %0d extra %0d, want 0 0 0", o.memreq, o.tagwe, o.extra);
    end
    n_vec++;
    if (bus.HIT_CNT !== m_hit || bus.MISS_CNT !== m_miss) begin
      n_bad++; $display("FAIL hit_cnt: got %0d/%0d, want %0d/%0d", bus.HIT_CNT, bus.MISS_CNT, m_hit, m_miss);
    end
  endtask

  task automatic test_miss_fill;
    acc_t o, e;
    logic [13:0] cpns [2];
    int          acks [2];
    cpns[0] = 14'h01A5; cpns[1] = 14'h2B6C;
    acks[0] = 3;        acks[1] = 1;
    for (int i = 0; i < 2; i++) begin
      predict(cpns[i], 2'b11, 2'b10, acks[i], 1'b0, 1'b0);
      access(cpns[i], 2'b11, 2'b10, acks[i], 1'b0, 1'b0, 0, o);
      e = exp_q.pop_front();
      n_vec++;
      if (o.lat !== e.lat || o.done !== e.done || o.extra !== 0) begin
        n_bad++; $display("FAIL miss_done[%0d]: got lat %0d done %b extra %0d, want lat %0d done %b extra 0", i, o.lat, o.done, o.extra, e.lat, e.done);
      end
      n_vec++;
      if (o.memreq !== e.memreq || o.tagwe !== e.tagwe) begin
        n_bad++; $display("FAIL miss_fill[%0d]: got memreq %0d tagwe %0d, want %0d %0d", i, o.memreq, o.tagwe, e.memreq, e.tagwe);
      end
      n_vec++;
      if (o.bank !== e.bank || o.data !== e.data) begin
        n_bad++; $display("FAIL miss_tag[%0d]: got bank %b data %h, want bank %b data %h", i, o.bank, o.data, e.bank, e.data);
      end
      n_vec++;
      if (bus.HIT_CNT !== m_hit || bus.MISS_CNT !== m_miss) begin
        n_bad++; $display("FAIL miss_cnt[%0d]: got %0d/%0d, want %0d/%0d", i, bus.HIT_CNT, bus.MISS_CNT, m_hit, m_miss);
      end
    end
  endtask

  task automatic test_retry_miss;
    acc_t o, e;
    bus.CLR_CNT = 1'b1;
    @(posedge sysclk); #1;
    bus.CLR_CNT = 1'b0;
    m_hit = 16'd0; m_miss = 16'd0;
    n_vec++;
    if (bus.HIT_CNT !== m_hit || bus.MISS_CNT !== m_miss) begin
      n_bad++; $display("FAIL clr_alone: got %0d/%0d, want 0/0", bus.HIT_CNT, bus.MISS_CNT);
    end
    predict(14'h0777, 2'b11, 2'b11, 2, 1'b0, 1'b0);
    access(14'h0777, 2'b11, 2'b11, 2, 1'b0, 1'b0, 0, o);
    e = exp_q.pop_front();
    n_vec++;
    if (o.lat !== e.lat || o.done !== e.done || o.extra !== 0) begin
      n_bad++; $display("FAIL retry_err: got lat %0d done %b extra %0d, want lat %0d done %b extra 0", o.lat, o.done, o.extra, e.lat, e.done);
    end
    n_vec++;
    if (o.tagwe !== e.tagwe || o.bank !== e.bank || o.data !== e.data) begin
      n_bad++; $display("FAIL retry_tag: got tagwe %0d bank %b data %h, want %0d %b %h", o.tagwe, o.bank, o.data, e.tagwe, e.bank, e.data);
    end
    n_vec++;
    if (bus.HIT_CNT !== m_hit || bus.MISS_CNT !== m_miss) begin
      n_bad++; $display("FAIL retry_cnt: got %0d/%0d, want %0d/%0d", bus.HIT_CNT, bus.MISS_CNT, m_hit, m_miss);
    end
  endtask

  task automatic test_timeout;
    acc_t o, e;
    int   acks [2];
    acks[0] = 0; acks[1] = TMO;
    for (int i = 0; i < 2; i++) begin
      predict(14'h1357, 2'b11, 2'b01, acks[i], 1'b0, 1'b0);
      access(14'h1357, 2'b11, 2'b01, acks[i], 1'b0, 1'b0, 0, o);
      e = exp_q.pop_front();
      n_vec++;
      if (o.memreq !== e.memreq || o.tagwe !== e.tagwe) begin
        n_bad++; $display("FAIL tmo_fill[%0d]: got memreq %0d tagwe %0d, want %0d %0d", i, o.memreq, o.tagwe, e.memreq, e.tagwe);
      end
      n_vec++;
      if (o.lat !== e.lat || o.done !== e.done || o.extra !== 0) begin
        n_bad++; $display("FAIL tmo_end[%0d]: got lat %0d done %b extra %0d, want lat %0d done %b extra 0", i, o.lat, o.done, o.extra, e.lat, e.done);
      end
      n_vec++;
      if (bus.TAG_BANK !== m_victim) begin
        n_bad++; $display("FAIL tmo_victim[%0d]: got %b, want %b", i, bus.TAG_BANK, m_victim);
      end
    end
  endtask

  task automatic test_mem_err;
    acc_t o, e;
    predict(14'h0F0F, 2'b11, 2'b00, 2, 1'b1, 1'b0);
    access(14'h0F0F, 2'b11, 2'b00, 2, 1'b1, 1'b0, 6, o);
    e = exp_q.pop_front();
    n_vec++;
    if (o.lat !== e.lat || o.done !== e.done) begin
      n_bad++; $display("FAIL memerr_end: got lat %0d done %b, want lat %0d done %b", o.lat, o.done, e.lat, e.done);
    end
    n_vec++;
    if (o.tagwe !== 0 || o.memreq !== e.memreq) begin
      n_bad++; $display("FAIL memerr_fill: got tagwe %0d memreq %0d, want 0 %0d", o.tagwe, o.memreq, e.memreq);
    end
    n_vec++;
    if (o.extra !== 0) begin
      n_bad++; $display("FAIL memerr_release: got %0d stray events while REQ held, want 0", o.extra);
    end
  endtask

  task automatic test_clr_cnt;
    acc_t o, e;
    logic [1:0] firsts [2];
    firsts[0] = 2'b10; firsts[1] = 2'b11;
    for (int i = 0; i < 2; i++) begin
      predict(14'h0042, firsts[i], 2'b10, 1, 1'b0, 1'b1);
      access(14'h0042, firsts[i], 2'b10, 1, 1'b0, 1'b1, 0, o);
      e = exp_q.pop_front();
      n_vec++;
      if (bus.HIT_CNT !== m_hit || bus.MISS_CNT !== m_miss) begin
        n_bad++; $display("FAIL clr_vs_inc[%0d]: got %0d/%0d, want %0d/%0d", i, bus.HIT_CNT, bus.MISS_CNT, m_hit, m_miss);
      end
      n_vec++;
      if (o.lat !== e.lat || o.done !== e.done) begin
        n_bad++; $display("FAIL clr_access[%0d]: got lat %0d done %b, want lat %0d done %b", i, o.lat, o.done, e.lat, e.done);
      end
    end
  endtask

  task automatic test_back_to_back;
    acc_t o, e;
    logic [13:0] cpn;
    logic [1:0]  f_n, r_n;
    int          ack;
    logic        er;
    for (int i = 0; i < 12; i++) begin
      cpn = 14'($urandom);
      f_n = 2'($urandom_range(3, 0));
      r_n = 2'($urandom_range(3, 0));
      ack = int'($urandom_range(5, 0));
      er  = ($urandom_range(3, 0) == 0);
      predict(cpn, f_n, r_n, ack, er, 1'b0);
      access(cpn, f_n, r_n, ack, er, 1'b0, 0, o);
      e = exp_q.pop_front();
      n_vec++;
      if (o.lat !== e.lat || o.done !== e.done || o.memreq !== e.memreq || o.tagwe !== e.tagwe || o.extra !== 0) begin
        n_bad++; $display("FAIL b2b_flow[%0d]: got lat %0d done %b memreq %0d tagwe %0d extra %0d, want %0d %b %0d %0d 0", i, o.lat, o.done, o.memreq, o.tagwe, o.extra, e.lat, e.done, e.memreq, e.tagwe);
      end
      n_vec++;
      if (e.tagwe == 1 && (o.bank !== e.bank || o.data !== e.data)) begin
        n_bad++; $display("FAIL b2b_tag[%0d]: got bank %b data %h, want bank %b data %h", i, o.bank, o.data, e.bank, e.data);
      end
      n_vec++;
      if (bus.HIT_CNT !== m_hit || bus.MISS_CNT !== m_miss) begin
        n_bad++; $display("FAIL b2b_cnt[%0d]: got %0d/%0d, want %0d/%0d", i, bus.HIT_CNT, bus.MISS_CNT, m_hit, m_miss);
      end
    end
  endtask

  task automatic test_counter_sat;
    acc_t o, e;
    int   bad_lat;
    bus.CLR_CNT = 1'b1;
    @(posedge sysclk); #1;
    bus.CLR_CNT = 1'b0;
    m_hit = 16'd0; m_miss = 16'd0;
    bad_lat = 0;
    for (int i = 0; i < 65535; i++) begin
      predict(14'h0001, 2'b10, 2'b11, 0, 1'b0, 1'b0);
      access(14'h0001, 2'b10, 2'b11, 0, 1'b0, 1'b0, 0, o);
      e = exp_q.pop_front();
      if (o.lat !== e.lat || o.done !== e.done) bad_lat++;
    end
    n_vec++;
    if (bad_lat !== 0) begin
      n_bad++; $display("FAIL sat_accesses: got %0d bad hit accesses, want 0", bad_lat);
    end
    n_vec++;
    if (bus.HIT_CNT !== m_hit) begin
      n_bad++; $display("FAIL sat_preload: got %h, want %h", bus.HIT_CNT, m_hit);
    end
    predict(14'h0001, 2'b10, 2'b11, 0, 1'b0, 1'b0);
    access(14'h0001, 2'b10, 2'b11, 0, 1'b0, 1'b0, 0, o);
    e = exp_q.pop_front();
    n_vec++;
    if (bus.HIT_CNT !== m_hit || bus.MISS_CNT !== m_miss) begin
      n_bad++; $display("FAIL sat_hold: got %h/%h, want %h/%h", bus.HIT_CNT, bus.MISS_CNT, m_hit, m_miss);
    end
  endtask

  task automatic test_rst_in_fill;
    acc_t o, e;
    bit   seen;
    bus.CPN_23_10 = 14'h3FFF;
    bus.HIT0_n = 1'b1; bus.HIT1_n = 1'b1;
    bus.REQ = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(posedge sysclk); #1;
      if (bus.MEM_REQ) seen = 1'b1;
    end
    n_vec++;
    if (!seen) begin
      n_bad++; $display("FAIL rst_fill_entry: got no MEM_REQ, want MEM_REQ");
    end
    @(posedge sysclk); #2;
    sys_rst = 1'b1;
    #1;
    m_hit = 16'd0; m_miss = 16'd0; m_victim = 1'b0;
    n_vec++;
    if ({bus.MEM_REQ, bus.TAG_WE, bus.TAG_BANK, bus.DONE, bus.ERR} !== 5'b00000) begin
      n_bad++; $display("FAIL rst_fill_ctrl: got %b, want 00000", {bus.MEM_REQ, bus.TAG_WE, bus.TAG_BANK, bus.DONE, bus.ERR});
    end
    n_vec++;
    if (bus.TAG_DATA !== 14'd0 || bus.HIT_CNT !== m_hit || bus.MISS_CNT !== m_miss) begin
      n_bad++; $display("FAIL rst_fill_data: got %h/%h/%h, want 0/0/0", bus.TAG_DATA, bus.HIT_CNT, bus.MISS_CNT);
    end
    bus.REQ = 1'b0;
    @(negedge sysclk);
    sys_rst = 1'b0;
    @(posedge sysclk); #1;
    predict(14'h0055, 2'b01, 2'b11, 0, 1'b0, 1'b0);
    access(14'h0055, 2'b01, 2'b11, 0, 1'b0, 1'b0, 0, o);
    e = exp_q.pop_front();
    n_vec++;
    if (o.lat !== e.lat || o.done !== e.done || o.memreq !== 0 || bus.HIT_CNT !== m_hit) begin
      n_bad++; $display("FAIL rst_fill_after: got lat %0d done %b memreq %0d hit %0d, want %0d %b 0 %0d", o.lat, o.done, o.memreq, bus.HIT_CNT, e.lat, e.done, m_hit);
    end
  endtask

  initial begin
    test_reset();
    test_hit();
    test_miss_fill();
    test_retry_miss();
    test_timeout();
    test_mem_err();
    test_clr_cnt();
    test_back_to_back();
    test_counter_sat();
    test_rst_in_fill();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
